mult_datapath: RTL
==================

# mult_datapath

Register/arithmetic datapath for the 8-bit signed (two's-complement) shift-add multiplier. Executes the per-cycle commands issued by the multiplier control FSM: clear, load, add/subtract, arithmetic right shift. Holds the 17-bit product X:A:B and returns the current multiplier LSB `M` to the FSM. Sits directly downstream of the control unit and drives the hex/LED display logic.

## Interface
- No parameters; width fixed at 8 bits per register.
- `Clk` in 1: system clock; all state updates on rising edge.
- `Reset` in 1: asynchronous, active-high; clears all state immediately.
- `S` in 8: switch operand; multiplier source on load, multiplicand source on `Clear_A`.
- `ClearA_LoadB` in 1: synchronous clear of A and X and load of B from `S`.
- `Clear_A` in 1: synchronous clear of A and X; snapshot `S` into the multiplicand register.
- `Adder_en_A` in 1: write adder sum[7:0] into A.
- `Adder_en_X` in 1: write adder sum[8] into X.
- `Adder_en_B` in 1: reserved; ignored.
- `Sub_Add` in 1: 1 = subtract multiplicand, 0 = add.
- `ShiftA`, `ShiftB`, `ShiftX` in 1 each: per-register arithmetic-right-shift enables.
- `M` out 1: B[0], combinational from the B register.
- `Aval` out 8: A register. `Bval` out 8: B register. `Xval` out 1: X register.

## Operation
- State: A[7:0], B[7:0], X, Sreg[7:0] (multiplicand snapshot). All reset to 0; every output reads 0 during and immediately after `Reset`.
- Adder: 9-bit, sign-extended. sum = {A[7],A} + ({Sreg[7],Sreg} XOR {9{Sub_Add}}) + Sub_Add, modulo 2^9. Operand is always Sreg, never live `S`.
- Shift (the value is taken from the pre-edge state):
  - `ShiftX`: X <= X, sign retained.
  - `ShiftA`: A <= {X, A[7:1]}.
  - `ShiftB`: B <= {A[0], B[7:1]}.
- Per-edge priority, highest first; exactly one class acts per edge:
  1. `ClearA_LoadB`: A <= 0, X <= 0, B <= S. Sreg unchanged.
  2. `Clear_A`: A <= 0, X <= 0, Sreg <= S. B unchanged.
  3. Any `Adder_en_A`/`Adder_en_X`: each enabled target is written from the sum; non-enabled targets hold. Shift enables on the same edge are ignored.
  4. Any shift enable: each enabled register shifts independently.
  5. Otherwise all registers hold.
- `S` may change at any time. Only the edges with `ClearA_LoadB` or `Clear_A` asserted sample it.
- A full multiply produces the signed 16-bit product in {A,B}, with X equal to A[7].
  - The command sequence is: Clear_A, then 7 × (add-if-M, shift), then 1 × (sub-if-M, shift).
  - -128 × -128 = +16384 is representable and must be exact.

## Timing
- All writes take effect on the edge where the command is asserted. Results are visible on the outputs the following cycle. Latency is 1 cycle.
- `M` changes only after an edge that writes B (load or `ShiftB`). It is stable across an add cycle, so the FSM's next decision uses the updated B.
- Asynchronous reset:
  - Asserting `Reset` mid-multiply zeroes A, B, X and Sreg without waiting for an edge.
  - On deassertion, the first edge obeys the inputs present at that edge.
- Full multiply under the FSM takes 17 active edges after `Clear_A` (8 add/sub slots + 8 shifts + trailing idle). The datapath adds no stall.
- No handshake: every command is accepted unconditionally on its edge.

## Test plan
- Reset mid-operation: A=0x5A, B=0x3C, X=1, then pulse `Reset` between edges -> all outputs 0 before the next edge, `M`=0.
- Load/priority: S=0x07 with `ClearA_LoadB`=`Clear_A`=`ShiftA`=1 for one edge -> B=0x07, A=0x00, X=0, Sreg unchanged, `M`=1.
- Add sign extension: Sreg=0x80, A=0x00, add with both enables -> A=0x80, X=1. Subtract from A=0x00, Sreg=0x80 -> A=0x80, X=0.
- Shift: X=1, A=0x81, B=0x02 with all three shift enables -> X=1, A=0xC0, B=0x81, `M`=1. With only `ShiftB` -> A unchanged, B=0x81.
- Full multiply using the scripted FSM command sequence:
  - B=0x07, S=0x03 at `Clear_A` -> A=0x00, B=0x15, X=0.
  - B=0xFE, S=0x05 -> A=0xFF, B=0xF6, X=1.
  - B=0x80, S=0x80 -> A=0x40, B=0x00, X=0.
- Live-switch isolation: change `S` to 0xFF after `Clear_A` during a 0x07×0x03 multiply -> result is still 0x0015.

Source files
------------

// File: rtl/mult_datapath_if.sv
// -----------------------------------------------------------------------------
// mult_datapath_if
// Command/status bundle between the multiplier control FSM and its datapath.
//   S            : 8-bit switch operand (multiplier on load, multiplicand on Clear_A)
//   ClearA_LoadB : clear A/X, load B from S
//   Clear_A      : clear A/X, snapshot S as multiplicand
//   Adder_en_A/X : write adder sum[7:0] to A / sum[8] to X
//   Adder_en_B   : reserved, ignored by the datapath
//   Sub_Add      : 1 = subtract multiplicand, 0 = add
//   ShiftA/B/X   : per-register arithmetic right shift enables
//   M            : current multiplier LSB (B[0]) back to the FSM
//   Aval/Bval/Xval : register contents for display
// The master modport is the control unit; the slave modport is the datapath.
// -----------------------------------------------------------------------------
interface mult_datapath_if;
    logic [7:0] S;
    logic       ClearA_LoadB;
    logic       Clear_A;
    logic       Adder_en_A;
    logic       Adder_en_X;
    logic       Adder_en_B;
    logic       Sub_Add;
    logic       ShiftA;
    logic       ShiftB;
    logic       ShiftX;
    logic       M;
    logic [7:0] Aval;
    logic [7:0] Bval;
    logic       Xval;

    modport master (
        output S, ClearA_LoadB, Clear_A, Adder_en_A, Adder_en_X, Adder_en_B,
               Sub_Add, ShiftA, ShiftB, ShiftX,
        input  M, Aval, Bval, Xval
    );

    modport slave (
        input  S, ClearA_LoadB, Clear_A, Adder_en_A, Adder_en_X, Adder_en_B,
               Sub_Add, ShiftA, ShiftB, ShiftX,
        output M, Aval, Bval, Xval
    );
endinterface

// File: rtl/mult_datapath.sv
// -----------------------------------------------------------------------------
// mult_datapath
// Register/arithmetic datapath of the 8-bit signed shift-add multiplier.
// Holds the product X:A:B plus a multiplicand snapshot (Sreg) and executes one
// command class per rising edge: load, clear, add/subtract, or shift.
//   Clk   : system clock, rising edge
//   Reset : asynchronous, active-high; zeroes A, B, X and Sreg
//   bus   : mult_datapath_if.slave (commands in; M, Aval, Bval, Xval out)
// -----------------------------------------------------------------------------
module mult_datapath (
    input  logic             Clk,
    input  logic             Reset,
    mult_datapath_if.slave   bus
);

    typedef enum logic [2:0] {
        OP_LOAD_B,
        OP_CLEAR_A,
        OP_ADD,
        OP_SHIFT,
        OP_HOLD
    } op_e;

    logic [7:0] a_reg;
    logic [7:0] b_reg;
    logic       x_reg;
    logic [7:0] s_reg;

    logic [8:0] operand;
    logic [8:0] sum;
    op_e        op;

    // The reserved B enable has no effect on this datapath.
    logic unused_adder_en_b;
    assign unused_adder_en_b = bus.Adder_en_B;

    // Sign-extended 9-bit adder; subtraction is add of the inverted operand
    // plus one. The operand is always the snapshot, never the live switches.
    always_comb begin
        operand = {s_reg[7], s_reg} ^ {9{bus.Sub_Add}};
        sum     = {a_reg[7], a_reg} + operand + {8'd0, bus.Sub_Add};
    end

    // Decode the single command class that acts on this edge.
    always_comb begin
        // NOTE: default first so every path assigns op and no latch is inferred.
        op = OP_HOLD;
        if (bus.ClearA_LoadB)
            op = OP_LOAD_B;
        else if (bus.Clear_A)
            op = OP_CLEAR_A;
        else if (bus.Adder_en_A || bus.Adder_en_X)
            op = OP_ADD;
        else if (bus.ShiftA || bus.ShiftB || bus.ShiftX)
            op = OP_SHIFT;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            a_reg <= 8'h00;
            b_reg <= 8'h00;
            x_reg <= 1'b0;
            s_reg <= 8'h00;
        end else begin
            // NOTE: non-blocking so every shift below sees the pre-edge values
            // of its neighbours (A[0] into B, X into A).
            unique case (op)
                OP_LOAD_B: begin
                    a_reg <= 8'h00;
                    x_reg <= 1'b0;
                    b_reg <= bus.S;
                end
                OP_CLEAR_A: begin
                    a_reg <= 8'h00;
                    x_reg <= 1'b0;
                    s_reg <= bus.S;
                end
                OP_ADD: begin
                    if (bus.Adder_en_A) a_reg <= sum[7:0];
                    if (bus.Adder_en_X) x_reg <= sum[8];
                end
                OP_SHIFT: begin
                    // X is the sign bit of the product, so its shift keeps it.
                    if (bus.ShiftX) x_reg <= x_reg;
                    if (bus.ShiftA) a_reg <= {x_reg, a_reg[7:1]};
                    if (bus.ShiftB) b_reg <= {a_reg[0], b_reg[7:1]};
                end
                default: ;
            endcase
        end
    end

    assign bus.M    = b_reg[0];
    assign bus.Aval = a_reg;
    assign bus.Bval = b_reg;
    assign bus.Xval = x_reg;

endmodule
